// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with a registered winner index,
// one-hot grant decode, release on done/drop and an optional hold timeout.
module rr_decode_arbiter #(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    logic [0:0]        state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        gnt_q, gnt_d;

    logic              rel_done, rel_drop, rel_to;
    logic [7:0]        srch_req;
    logic [3:0]        srch;

    // Returns {hit, index}; scanning downward lets the nearest slot after p win.
    function automatic logic [3:0] rr_search(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] cand;
        res = '0;
        for (int i = 8; i >= 1; i--) begin
            cand = p + i[2:0];
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        rel_done  = done;
        rel_drop  = ~req[idx_q];
        rel_to    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
        srch_req  = req;
        srch      = rr_search(req, ptr_q);

        case (state_q)
            S_IDLE: begin
                if (srch[3]) begin
                    state_d = S_GRANT;
                    idx_d   = srch[2:0];
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            default: begin
                if (rel_done || rel_drop || rel_to) begin
                    // Timeout only reported when it is the sole reason for release.
                    timeout_d = rel_to && !rel_done && !rel_drop;
                    ptr_d     = idx_q;
                    if (!rel_done && rel_drop) srch_req[idx_q] = 1'b0;
                    srch = rr_search(srch_req, idx_q);
                    if (srch[3]) begin
                        idx_d  = srch[2:0];
                        hold_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                    end
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase

        gnt_d = valid_d ? (8'd1 << idx_d) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 3'd7;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            gnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            gnt_q     <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed + random bench for rr_decode_arbiter; a behavioural model feeds an
// expected-output queue that is drained after every clock edge.
module tb_rr_decode_arbiter;

    localparam int MAXH = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic       m_valid;
    logic [2:0] m_idx;
    int         m_ptr;
    int         m_hold;
    logic       m_to;

    rr_decode_arbiter #(.HOLD_W(4), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] pick(input logic [7:0] r, input int p);
        for (int k = 1; k <= 8; k++)
            if (r[(p + k) % 8]) return 3'((p + k) % 8);
        return 3'd0;
    endfunction

    task automatic model_next(input logic [7:0] r, input logic d, input logic rs);
        logic lim;
        m_to = 1'b0;
        if (rs) begin
            m_valid = 1'b0; m_idx = 3'd0; m_ptr = 7; m_hold = 0;
        end else if (!m_valid) begin
            if (r != 8'd0) begin
                m_idx = pick(r, m_ptr); m_valid = 1'b1; m_hold = 0;
            end
        end else begin
            lim = (MAXH != 0) && (m_hold == MAXH - 1);
            if (d || !r[m_idx] || lim) begin
                m_to  = lim && !d && r[m_idx];
                m_ptr = int'(m_idx);
                if (r != 8'd0) begin
                    m_idx = pick(r, m_ptr); m_hold = 0;
                end else begin
                    m_valid = 1'b0;
                end
            end else if (m_hold < 15) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic step(input string tag, input logic [7:0] r, input logic d, input logic rs);
        exp_t e, got;
        req = r; done = d; rst = rs;
        model_next(r, d, rs);
        e.gnt = m_valid ? (8'd1 << m_idx) : 8'd0;
        e.idx = m_idx; e.valid = m_valid; e.to = m_to;
        sb.push_back(e);
        @(posedge clk); #1;
        e   = sb.pop_front();
        got = '{gnt: gnt, idx: gnt_idx, valid: gnt_valid, to: timeout};
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                   tag, got.gnt, got.idx, got.valid, got.to, e.gnt, e.idx, e.valid, e.to);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    initial begin
        int tos;
        logic [7:0] rr;
        req = '0; done = 1'b0; rst = 1'b1;
        m_valid = 1'b0; m_idx = 3'd0; m_ptr = 7; m_hold = 0; m_to = 1'b0;

        // Reset and first grant
        step("reset", 8'h00, 1'b0, 1'b1);
        step("reset2", 8'h00, 1'b0, 1'b1);
        chk("reset_gnt", {gnt_valid, timeout, gnt_idx, 2'b00} | gnt, 8'h00);
        step("idle", 8'h00, 1'b0, 1'b0);
        step("first", 8'h01, 1'b0, 1'b0);
        chk("first_gnt", gnt, 8'h01);

        // Full rotation with done every cycle
        step("rot_rst", 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step("rot", 8'hFF, 1'b1, 1'b0);
            chk("rot_seq", gnt, 8'd1 << (k % 8));
        end

        // Hold-limit timeout between two requesters
        step("to_rst", 8'h00, 1'b0, 1'b1);
        tos = 0;
        for (int k = 1; k <= 31; k++) begin
            step("to", 8'h81, 1'b0, 1'b0);
            if (timeout) tos++;
            if (k == 15) chk("to_hold01", gnt, 8'h01);
            if (k == 16) chk("to_switch80", gnt, 8'h80);
            if (k == 31) chk("to_back01", gnt, 8'h01);
        end
        chk("to_count", 8'(tos), 8'd2);

        // Owner drops its request
        step("drop_rst", 8'h00, 1'b0, 1'b1);
        step("drop", 8'h48, 1'b0, 1'b0);
        chk("drop_own3", gnt, 8'h08);
        step("drop", 8'h40, 1'b0, 1'b0);
        chk("drop_to40", gnt, 8'h40);
        step("drop", 8'h00, 1'b0, 1'b0);
        chk("drop_idle", {7'd0, gnt_valid} | gnt, 8'h00);

        // done coincides with the hold limit
        step("lim_rst", 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 15; k++) step("lim", 8'h03, 1'b0, 1'b0);
        step("lim", 8'h03, 1'b1, 1'b0);
        chk("lim_rotate", gnt, 8'h02);
        chk("lim_no_to", {7'd0, timeout}, 8'h00);

        // Reset mid-grant, then rotation resumes from index 0
        step("mid_rst", 8'h00, 1'b0, 1'b1);
        step("mid", 8'h10, 1'b0, 1'b0);
        step("mid", 8'h10, 1'b0, 1'b0);
        step("mid", 8'h10, 1'b0, 1'b1);
        chk("mid_rst_gnt", gnt, 8'h00);
        step("mid", 8'h10, 1'b0, 1'b0);
        chk("mid_regrant", gnt, 8'h10);
        step("mid", 8'h11, 1'b1, 1'b0);
        chk("mid_next", gnt, 8'h01);

        // Sole requester released by done is re-granted
        step("self", 8'h01, 1'b1, 1'b0);
        chk("self_regrant", gnt, 8'h01);

        // Random traffic against the model
        for (int k = 0; k < 300; k++) begin
            rr = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rr = 8'd1 << $urandom_range(0, 7);
            step("rand", rr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
